// File: rtl/keccak_pkg.sv
// Shared types and constants for the keccak byte packer: FSM states, word geometry
// and the byte_num encodings understood by the keccak core.
package keccak_pkg;

    typedef enum logic [1:0] {
        CORE_RST = 2'd0,
        FILL     = 2'd1,
        SEND     = 2'd2,
        WAIT_OUT = 2'd3
    } state_e;

    localparam int WORD_BYTES = 4;

    // byte_num: number of valid bytes in a last word; 0 means a full (or zero tail) word
    localparam logic [1:0] BN_FULL  = 2'd0;
    localparam logic [1:0] BN_ONE   = 2'd1;
    localparam logic [1:0] BN_TWO   = 2'd2;
    localparam logic [1:0] BN_THREE = 2'd3;

    // Big-endian placement: byte index 0 lands in [31:24], index 3 in [7:0]
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [7:0]  b,
                                                input logic [1:0]  idx);
        logic [31:0] r;
        r = word;
        case (idx)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/keccak_byte_packer.sv
// Packs a valid/ready/last byte stream big-endian into 32-bit words for the keccak core,
// sequencing core reset, tail words and digest completion per message.
module keccak_byte_packer
    import keccak_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       s_byte,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic             core_reset,
    output logic [31:0]      k_in,
    output logic             k_in_ready,
    output logic             k_is_last,
    output logic [1:0]       k_byte_num,
    input  logic             k_buffer_full,
    input  logic             k_out_ready,
    output logic             msg_done,
    output logic [LEN_W-1:0] msg_bytes
);

    state_e           state_q, state_d;
    logic [31:0]      fill_q, fill_d;
    logic [1:0]       idx_q, idx_d;
    logic             pend_tail_q, pend_tail_d;
    logic             s_ready_q, s_ready_d;
    logic             core_reset_q, core_reset_d;
    logic [31:0]      k_in_q, k_in_d;
    logic             k_in_ready_q, k_in_ready_d;
    logic             k_is_last_q, k_is_last_d;
    logic [1:0]       k_byte_num_q, k_byte_num_d;
    logic             msg_done_q, msg_done_d;
    logic [LEN_W-1:0] msg_bytes_q, msg_bytes_d;

    logic        byte_xfer;
    logic        word_acc;
    logic        word_end;
    logic [31:0] packed_word;

    assign byte_xfer   = s_valid && s_ready_q;
    assign word_acc    = k_in_ready_q && !k_buffer_full;
    assign word_end    = (idx_q == 2'(WORD_BYTES - 1)) || s_last;
    assign packed_word = insert_byte(fill_q, s_byte, idx_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CORE_RST;
            fill_q       <= '0;
            idx_q        <= '0;
            pend_tail_q  <= 1'b0;
            s_ready_q    <= 1'b0;
            core_reset_q <= 1'b1;
            k_in_q       <= '0;
            k_in_ready_q <= 1'b0;
            k_is_last_q  <= 1'b0;
            k_byte_num_q <= BN_FULL;
            msg_done_q   <= 1'b0;
            msg_bytes_q  <= '0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            idx_q        <= idx_d;
            pend_tail_q  <= pend_tail_d;
            s_ready_q    <= s_ready_d;
            core_reset_q <= core_reset_d;
            k_in_q       <= k_in_d;
            k_in_ready_q <= k_in_ready_d;
            k_is_last_q  <= k_is_last_d;
            k_byte_num_q <= k_byte_num_d;
            msg_done_q   <= msg_done_d;
            msg_bytes_q  <= msg_bytes_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CORE_RST: state_d = FILL;
            FILL:     if (byte_xfer && word_end) state_d = SEND;
            SEND:     if (word_acc && !pend_tail_q) state_d = k_is_last_q ? WAIT_OUT : FILL;
            WAIT_OUT: if (k_out_ready) state_d = CORE_RST;
            default:  state_d = CORE_RST;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q
    always_comb begin
        fill_d       = fill_q;
        idx_d        = idx_q;
        pend_tail_d  = pend_tail_q;
        k_in_d       = k_in_q;
        k_is_last_d  = k_is_last_q;
        k_byte_num_d = k_byte_num_q;
        msg_bytes_d  = msg_bytes_q;
        msg_done_d   = 1'b0;
        case (state_q)
            CORE_RST: begin
                fill_d      = '0;
                idx_d       = '0;
                pend_tail_d = 1'b0;
                msg_bytes_d = '0;
            end
            FILL: begin
                if (byte_xfer) begin
                    if (msg_bytes_q != '1) msg_bytes_d = msg_bytes_q + 1'b1;
                    if (word_end) begin
                        k_in_d       = packed_word;
                        fill_d       = '0;
                        idx_d        = '0;
                        // A last byte filling the word still needs a zero tail word
                        pend_tail_d  = s_last && (idx_q == 2'(WORD_BYTES - 1));
                        k_is_last_d  = s_last && (idx_q != 2'(WORD_BYTES - 1));
                        k_byte_num_d = k_is_last_d ? idx_q + 2'd1 : BN_FULL;
                    end else begin
                        fill_d = packed_word;
                        idx_d  = idx_q + 2'd1;
                    end
                end
            end
            SEND: begin
                if (word_acc && pend_tail_q) begin
                    k_in_d       = '0;
                    k_is_last_d  = 1'b1;
                    k_byte_num_d = BN_FULL;
                    pend_tail_d  = 1'b0;
                end
            end
            WAIT_OUT: msg_done_d = k_out_ready;
            default: ;
        endcase
        s_ready_d    = (state_d == FILL);
        core_reset_d = (state_d == CORE_RST);
        k_in_ready_d = (state_d == SEND);
    end

    assign s_ready    = s_ready_q;
    assign core_reset = core_reset_q;
    assign k_in       = k_in_q;
    assign k_in_ready = k_in_ready_q;
    assign k_is_last  = k_is_last_q;
    assign k_byte_num = k_byte_num_q;
    assign msg_done   = msg_done_q;
    assign msg_bytes  = msg_bytes_q;

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Directed bench for keccak_byte_packer with a small keccak-core stand-in that logs
// accepted words, applies buffer_full stalls and answers with out_ready.
module tb_keccak_byte_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_byte;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        core_reset;
    logic [31:0] k_in;
    logic        k_in_ready;
    logic        k_is_last;
    logic [1:0]  k_byte_num;
    logic        k_buffer_full;
    logic        k_out_ready;
    logic        msg_done;
    logic [15:0] msg_bytes;

    always #5 clk = ~clk;

    keccak_byte_packer #(.LEN_W(16)) dut (
        .clk(clk), .reset(reset),
        .s_byte(s_byte), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .core_reset(core_reset), .k_in(k_in), .k_in_ready(k_in_ready),
        .k_is_last(k_is_last), .k_byte_num(k_byte_num),
        .k_buffer_full(k_buffer_full), .k_out_ready(k_out_ready),
        .msg_done(msg_done), .msg_bytes(msg_bytes)
    );

    int passed = 0;
    int total  = 0;

    logic [31:0] w_log[$];
    logic        l_log[$];
    logic [1:0]  bn_log[$];
    int          ko_cnt = 0;
    int          cr_cycles = 0;
    int          done_pulses = 0;
    int          sready_bad = 0;
    bit          busy = 1'b0;
    int          stall_idx = -1;
    int          stall_left = 0;
    bit          stall_started = 1'b0;
    int          stall_bad = 0;
    logic [31:0] held_w;
    logic        held_l;
    logic [1:0]  held_bn;

    // Core stand-in: samples on the falling edge, drives buffer_full/out_ready for the next rise
    always @(negedge clk) begin
        if (reset) begin
            k_buffer_full = 1'b0;
            k_out_ready   = 1'b0;
            ko_cnt        = 0;
        end else begin
            k_out_ready = 1'b0;
            if (ko_cnt > 0) begin
                ko_cnt--;
                if (ko_cnt == 0) k_out_ready = 1'b1;
            end
            if (core_reset) cr_cycles++;
            if (msg_done) done_pulses++;
            if (busy && s_ready) sready_bad++;
            if (msg_done) busy = 1'b0;
            if (stall_started && stall_left > 0 && !k_in_ready) stall_bad++;
            if (k_in_ready) begin
                if (stall_left > 0 && w_log.size() == stall_idx) begin
                    if (!stall_started) begin
                        held_w = k_in; held_l = k_is_last; held_bn = k_byte_num;
                        stall_started = 1'b1;
                    end else if (k_in !== held_w || k_is_last !== held_l || k_byte_num !== held_bn) begin
                        stall_bad++;
                    end
                    k_buffer_full = 1'b1;
                    stall_left--;
                end else begin
                    k_buffer_full = 1'b0;
                    w_log.push_back(k_in);
                    l_log.push_back(k_is_last);
                    bn_log.push_back(k_byte_num);
                    if (k_is_last) ko_cnt = 3;
                end
            end else begin
                k_buffer_full = 1'b0;
            end
        end
    end

    task automatic clear_logs();
        w_log.delete(); l_log.delete(); bn_log.delete();
        done_pulses = 0; sready_bad = 0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit last, input int gap);
        bit got;
        s_byte = b; s_valid = 1'b1; s_last = last;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (s_ready) begin got = 1'b1; break; end
        end
        if (!got) begin
            total++;
            $display("FAIL push_timeout: s_ready stayed %b, required 1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0; s_byte = 8'h00;
        if (last) busy = 1'b1;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic run_msg(input string s, input int gap, output bit done_ok, output int bytes_at_done);
        for (int i = 0; i < s.len(); i++) push_byte(s[i], (i == s.len() - 1), gap);
        done_ok = 1'b0;
        bytes_at_done = -1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (msg_done) begin done_ok = 1'b1; bytes_at_done = int'(msg_bytes); break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_byte = 8'h00;
        k_buffer_full = 1'b0; k_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (s_ready !== 1'b0 || core_reset !== 1'b1 || k_in !== 32'h0 || k_in_ready !== 1'b0 ||
                     k_is_last !== 1'b0 || k_byte_num !== 2'd0 || msg_done !== 1'b0 || msg_bytes !== 16'd0)
            $display("FAIL reset_values: got rdy=%b crst=%b in=%h inr=%b last=%b bn=%0d done=%b bytes=%0d",
                     s_ready, core_reset, k_in, k_in_ready, k_is_last, k_byte_num, msg_done, msg_bytes);
        else passed++;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        total++; if (core_reset !== 1'b1 || s_ready !== 1'b0)
            $display("FAIL core_rst_pulse: got crst=%b rdy=%b, required 1 0", core_reset, s_ready);
        else passed++;
        @(negedge clk);
        total++; if (core_reset !== 1'b0 || s_ready !== 1'b1)
            $display("FAIL enter_fill: got crst=%b rdy=%b, required 0 1", core_reset, s_ready);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_hello_13();
        logic [31:0] exp_w[$];
        bit ok; int nb;
        exp_w = '{32'h48656C6C, 32'h6F2C2077, 32'h6F726C64, 32'h21000000};
        clear_logs();
        run_msg("Hello, world!", 0, ok, nb);
        repeat (3) @(posedge clk); #1;
        total++; if (ok !== 1'b1 || done_pulses !== 1) $display("FAIL hello13_done: got seen=%b pulses=%0d, required 1 1", ok, done_pulses); else passed++;
        total++; if (nb !== 13) $display("FAIL hello13_bytes: got %0d required 13", nb); else passed++;
        total++; if (w_log.size() !== exp_w.size()) $display("FAIL hello13_count: got %0d words required %0d", w_log.size(), exp_w.size()); else passed++;
        for (int i = 0; i < exp_w.size() && i < w_log.size(); i++) begin
            total++;
            if (w_log[i] !== exp_w[i] || l_log[i] !== (i == 3) || bn_log[i] !== ((i == 3) ? 2'd1 : 2'd0))
                $display("FAIL hello13_word%0d: got %h last=%b bn=%0d required %h last=%b bn=%0d",
                         i, w_log[i], l_log[i], bn_log[i], exp_w[i], (i == 3), (i == 3) ? 1 : 0);
            else passed++;
        end
    endtask

    task automatic test_hello_12_tail();
        logic [31:0] exp_w[$];
        bit ok; int nb;
        exp_w = '{32'h48656C6C, 32'h6F2C2077, 32'h6F726C64, 32'h00000000};
        clear_logs();
        run_msg("Hello, world", 0, ok, nb);
        total++; if (ok !== 1'b1 || nb !== 12) $display("FAIL hello12_done: got seen=%b bytes=%0d, required 1 12", ok, nb); else passed++;
        total++; if (w_log.size() !== exp_w.size()) $display("FAIL hello12_count: got %0d words required %0d", w_log.size(), exp_w.size()); else passed++;
        for (int i = 0; i < exp_w.size() && i < w_log.size(); i++) begin
            total++;
            if (w_log[i] !== exp_w[i] || l_log[i] !== (i == 3) || bn_log[i] !== 2'd0)
                $display("FAIL hello12_word%0d: got %h last=%b bn=%0d required %h last=%b bn=0",
                         i, w_log[i], l_log[i], bn_log[i], exp_w[i], (i == 3));
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w[$];
        bit ok; int nb;
        exp_w = '{32'h48656C6C, 32'h6F2C2077, 32'h6F726C64, 32'h21000000};
        clear_logs();
        stall_idx = 1; stall_left = 5; stall_started = 1'b0; stall_bad = 0;
        run_msg("Hello, world!", 0, ok, nb);
        total++; if (stall_left !== 0 || stall_bad !== 0) $display("FAIL stall_stable: got left=%0d unstable=%0d, required 0 0", stall_left, stall_bad); else passed++;
        total++; if (held_w !== 32'h6F2C2077) $display("FAIL stall_word: got %h required 6f2c2077", held_w); else passed++;
        total++; if (ok !== 1'b1 || w_log.size() !== exp_w.size()) $display("FAIL stall_count: got seen=%b words=%0d required 1 %0d", ok, w_log.size(), exp_w.size()); else passed++;
        for (int i = 0; i < exp_w.size() && i < w_log.size(); i++) begin
            total++;
            if (w_log[i] !== exp_w[i] || l_log[i] !== (i == 3) || bn_log[i] !== ((i == 3) ? 2'd1 : 2'd0))
                $display("FAIL stall_word%0d: got %h last=%b bn=%0d required %h", i, w_log[i], l_log[i], bn_log[i], exp_w[i]);
            else passed++;
        end
        stall_idx = -1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_a[$];
        logic [31:0] exp_b[$];
        bit ok1, ok2; int nb1, nb2, cr_between;
        exp_a = '{32'h31323334, 32'h35363738, 32'h39300000};
        exp_b = '{32'h70617373, 32'h776F7264, 32'h31323300};
        clear_logs();
        cr_cycles = 0;
        run_msg("1234567890", 0, ok1, nb1);
        cr_between = cr_cycles;
        total++; if (ok1 !== 1'b1 || nb1 !== 10) $display("FAIL b2b_first_done: got seen=%b bytes=%0d required 1 10", ok1, nb1); else passed++;
        total++; if (w_log.size() !== 3) $display("FAIL b2b_first_count: got %0d required 3", w_log.size()); else passed++;
        for (int i = 0; i < 3 && i < w_log.size(); i++) begin
            total++;
            if (w_log[i] !== exp_a[i] || l_log[i] !== (i == 2) || bn_log[i] !== ((i == 2) ? 2'd2 : 2'd0))
                $display("FAIL b2b_a_word%0d: got %h last=%b bn=%0d required %h", i, w_log[i], l_log[i], bn_log[i], exp_a[i]);
            else passed++;
        end
        w_log.delete(); l_log.delete(); bn_log.delete();
        run_msg("password123", 0, ok2, nb2);
        total++; if (cr_between !== 1) $display("FAIL b2b_core_reset: got %0d cycles required 1", cr_between); else passed++;
        total++; if (sready_bad !== 0) $display("FAIL b2b_sready_idle: got %0d busy cycles with s_ready=1 required 0", sready_bad); else passed++;
        total++; if (ok2 !== 1'b1 || nb2 !== 11 || done_pulses !== 2) $display("FAIL b2b_second_done: got seen=%b bytes=%0d pulses=%0d required 1 11 2", ok2, nb2, done_pulses); else passed++;
        for (int i = 0; i < 3 && i < w_log.size(); i++) begin
            total++;
            if (w_log[i] !== exp_b[i] || l_log[i] !== (i == 2) || bn_log[i] !== ((i == 2) ? 2'd3 : 2'd0))
                $display("FAIL b2b_b_word%0d: got %h last=%b bn=%0d required %h", i, w_log[i], l_log[i], bn_log[i], exp_b[i]);
            else passed++;
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] exp_w[$];
        bit ok; int nb;
        string pre;
        exp_w = '{32'h54686520, 32'h71756963, 32'h6B206272, 32'h6F776E20, 32'h666F782E, 32'h00000000};
        pre = "abcdef";
        for (int i = 0; i < pre.len(); i++) push_byte(pre[i], 1'b0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (s_ready !== 1'b0 || core_reset !== 1'b1 || k_in !== 32'h0 || k_in_ready !== 1'b0 ||
                     k_is_last !== 1'b0 || k_byte_num !== 2'd0 || msg_done !== 1'b0 || msg_bytes !== 16'd0)
            $display("FAIL midreset_values: got rdy=%b crst=%b in=%h inr=%b last=%b bn=%0d done=%b bytes=%0d",
                     s_ready, core_reset, k_in, k_in_ready, k_is_last, k_byte_num, msg_done, msg_bytes);
        else passed++;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        total++; if (core_reset !== 1'b1) $display("FAIL midreset_core_rst: got %b required 1", core_reset); else passed++;
        @(posedge clk); #1;
        clear_logs();
        run_msg("The quick brown fox.", 0, ok, nb);
        total++; if (ok !== 1'b1 || nb !== 20) $display("FAIL fox_done: got seen=%b bytes=%0d required 1 20", ok, nb); else passed++;
        total++; if (w_log.size() !== exp_w.size()) $display("FAIL fox_count: got %0d required %0d", w_log.size(), exp_w.size()); else passed++;
        for (int i = 0; i < exp_w.size() && i < w_log.size(); i++) begin
            total++;
            if (w_log[i] !== exp_w[i] || l_log[i] !== (i == 5) || bn_log[i] !== 2'd0)
                $display("FAIL fox_word%0d: got %h last=%b bn=%0d required %h", i, w_log[i], l_log[i], bn_log[i], exp_w[i]);
            else passed++;
        end
    endtask

    task automatic test_gapped_valid();
        logic [31:0] exp_w[$];
        bit ok; int nb;
        exp_w = '{32'h546F6461, 32'h79206973, 32'h20612073, 32'h756E6E79, 32'h20646179, 32'h2E000000};
        clear_logs();
        run_msg("Today is a sunny day.", 1, ok, nb);
        total++; if (ok !== 1'b1 || nb !== 21) $display("FAIL gap_done: got seen=%b bytes=%0d required 1 21", ok, nb); else passed++;
        total++; if (w_log.size() !== exp_w.size()) $display("FAIL gap_count: got %0d required %0d", w_log.size(), exp_w.size()); else passed++;
        for (int i = 0; i < exp_w.size() && i < w_log.size(); i++) begin
            total++;
            if (w_log[i] !== exp_w[i] || l_log[i] !== (i == 5) || bn_log[i] !== ((i == 5) ? 2'd1 : 2'd0))
                $display("FAIL gap_word%0d: got %h last=%b bn=%0d required %h", i, w_log[i], l_log[i], bn_log[i], exp_w[i]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_hello_13();
        test_hello_12_tail();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_gapped_valid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/keccak_byte_packer.md
Name: keccak_byte_packer

Overview:
- Upstream feeder for the keccak SHA-3 core. Takes a byte stream with valid/ready/last handshake and packs it big-endian into 32-bit words on the core's in/in_ready/is_last/byte_num interface.
- Honours buffer_full backpressure and pulses the core reset before each message.
- Waits for out_ready before accepting the next message, so software or a DMA can stream back-to-back messages without manual core sequencing.

Parameters:
LEN_W, 16, width of the per-message byte counter (saturating)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
s_byte  input  8  message byte
s_valid  input  1  s_byte valid
s_last  input  1  s_byte is final byte of message (message length >= 1)
s_ready  output  1  packer accepts s_byte this cycle
core_reset  output  1  drives keccak reset
k_in  output  32  word to keccak in
k_in_ready  output  1  drives keccak in_ready
k_is_last  output  1  drives keccak is_last
k_byte_num  output  2  drives keccak byte_num
k_buffer_full  input  1  keccak buffer_full
k_out_ready  input  1  keccak out_ready
msg_done  output  1  one-cycle pulse when digest valid (k_out_ready seen)
msg_bytes  output  LEN_W  byte count of current/last message, saturates at all-ones

Behaviour:
- Reset values: state=CORE_RST, core_reset=1, s_ready=0, k_in=0, k_in_ready=0, k_is_last=0, k_byte_num=0, msg_done=0, msg_bytes=0, word count=0.
- Reset mid-message drops the partial word and any pending send. The core is re-reset and msg_bytes is cleared.
- All outputs are registered.
- CORE_RST: core_reset=1 for exactly one cycle after reset deasserts (and one cycle between messages); msg_bytes cleared; then goes to FILL.
- FILL: s_ready=1, core_reset=0. A byte transfers on s_valid&&s_ready. Byte n of the word (n=0..3) goes to word bits [31-8n:24-8n], so the first byte lands in [31:24]. Each transfer increments msg_bytes.
  - 4th byte, not last -> SEND with the full word, is_last=0.
  - 4th byte with s_last -> SEND full word, is_last=0, and set pend_tail. After acceptance a second word k_in=0, is_last=1, byte_num=0 is sent.
  - n-th byte (n=1..3) with s_last -> SEND with k_in holding those bytes and unused low bytes zero, is_last=1, byte_num=n.
- SEND: s_ready=0, k_in_ready=1. The word is accepted at a posedge where k_in_ready=1 and k_buffer_full=0.
  - While k_buffer_full=1, k_in, k_is_last and k_byte_num hold stable.
  - On acceptance: if pend_tail, load the tail word and stay in SEND. Else if is_last, go to WAIT_OUT. Else go to FILL.
  - On acceptance k_in_ready drops the next cycle unless a tail word follows.
  - Latency: word presented the cycle after its last byte transfers.
- WAIT_OUT: all handshakes idle. The first cycle with k_out_ready=1 gives msg_done=1 the next cycle, then CORE_RST.
  - The digest must be sampled by the consumer before the next core_reset. It is valid on the k_out_ready cycle and the msg_done cycle.
- s_valid while s_ready=0 is ignored (no transfer). s_last without s_valid is ignored.
- Words are never sent with is_last=1 and byte_num=0 except as the zero tail word.

Decomposition:
- Shared package keccak_pkg: state enum {CORE_RST, FILL, SEND, WAIT_OUT}, constant WORD_BYTES=4, byte_num encodings.
- No sub-module; a single FSM plus a 32-bit shift/assembly register.

Test Plan:
- Message "Hello, world!" (13 bytes), no backpressure:
  - core_reset pulse, then k_in "Hell", "o, w", "orld" with is_last=0.
  - Then 0x21000000 with is_last=1, byte_num=1; msg_bytes=13.
  - After the core raises out_ready, digest matches the golden SHA3-512 model and msg_done pulses once.
- Message "Hello, world" (12 bytes): three full words, then k_in=0, is_last=1, byte_num=0. Digest matches the model.
- k_buffer_full forced to 1 for 5 cycles while "o, w" is presented: k_in/k_in_ready stable throughout, word accepted exactly once, digest unchanged versus the unstalled run.
- Back-to-back messages "1234567890" then "password123": exactly one one-cycle core_reset between them, s_ready=0 from the final byte until after msg_done, both digests correct.
- reset asserted after 6 bytes of a message: all outputs return to reset values, core_reset reasserts. A fresh "The quick brown fox." then hashes correctly with msg_bytes=20.
- s_valid toggling every other cycle on "Today is a sunny day." (21 bytes): final word has byte_num=1, digest correct.
